rom_fetch_arbiter: RTL and testbench
====================================

// Module: rom_fetch_arbiter
// PURPOSE
// - Shares the single-port synchronous instruction ROM between the IF stage fetch
//   port and the MEM-stage load port (constant/S-box/key tables held in ROM).
// - Grants at most one ROM access per cycle, returns read data one cycle later to
//   the owner, and raises a fetch stall request when IF loses arbitration.
// - Sits between the IF/MEM stages and the ROM; drives the pipeline stall controller.
// PARAMETERS
// - ADDR_W     32  ROM byte-address width (matches `InstAddrBus)
// - DATA_W     32  ROM word width (matches `InstBus)
// - STARVE_MAX 3   consecutive IF denials after which IF gets forced priority (1..15)
// PORTS
// - clk          in   1       system clock, rising edge
// - rst          in   1       asynchronous, active-high reset
// - if_req_i     in   1       IF requests fetch at if_addr_i this cycle
// - if_addr_i    in   ADDR_W  fetch address (the PC)
// - if_gnt_o     out  1       IF access issued to ROM this cycle
// - if_rvalid_o  out  1       if_rdata_o holds the word for last cycle's IF grant
// - if_rdata_o   out  DATA_W  fetched instruction
// - ls_req_i     in   1       MEM stage requests ROM read at ls_addr_i
// - ls_addr_i    in   ADDR_W  load address
// - ls_gnt_o     out  1       load access issued to ROM this cycle
// - ls_rvalid_o  out  1       ls_rdata_o holds the word for last cycle's LS grant
// - ls_rdata_o   out  DATA_W  loaded word
// - flush_i      in   1       branch/jump redirect: discard in-flight IF response
// - rom_ce_o     out  1       ROM chip enable
// - rom_addr_o   out  ADDR_W  ROM address
// - rom_data_i   in   DATA_W  ROM read data, valid the cycle after rom_ce_o
// - stall_req_o  out  1       IF needs the pipeline held this cycle
// BEHAVIOUR
// - Grant (combinational, same cycle as request):
//   - only if_req_i -> IF; only ls_req_i -> LS; neither -> none, rom_ce_o=0.
//   - both: LS wins, unless starve_cnt == STARVE_MAX, then IF wins.
//   - if_gnt_o & ls_gnt_o never both 1. rom_ce_o = if_gnt_o | ls_gnt_o.
//   - rom_addr_o = granted address; ZeroWord when no grant.
// - stall_req_o = if_req_i & ~if_gnt_o (combinational).
// - starve_cnt (4 bit): +1 (saturating at STARVE_MAX) when if_req_i & ~if_gnt_o;
//   cleared on any IF grant or when if_req_i=0.
// - Response owner register owner_q in {NONE, IF, LS}, loaded every cycle from the
//   grant; owner_q=IF with flush_i=1 in the grant cycle loads NONE instead.
// - Response (latency exactly 1): if_rvalid_o = (owner_q==IF) & ~flush_i;
//   ls_rvalid_o = (owner_q==LS). Both rdata outputs mirror rom_data_i when their
//   rvalid is 1, ZeroWord otherwise. flush_i in the response cycle also kills it.
// - Back-to-back grants allowed every cycle (fully pipelined, no bubbles).
// - flush_i never affects LS grants/responses nor the current-cycle IF grant.
// - Reset (async, any time, incl. mid-access): owner_q=NONE, starve_cnt=0; thus
//   if_rvalid_o=0, ls_rvalid_o=0, rdata=ZeroWord. Grant/stall outputs follow
//   inputs combinationally but are forced 0 while rst=1 (rom_ce_o=0).
// TESTING
// - Reset pulse mid-stream with if_req_i=1 -> all rvalid 0, owner NONE, rom_ce_o=0
//   while rst=1; first fetch after release returns data 1 cycle later.
// - IF alone, addrs 0x0,0x4,0x8 on 3 cycles -> rom_addr_o same cycles,
//   if_rvalid_o=1 cycles 2..4 with ROM words for 0x0,0x4,0x8, stall_req_o=0.
// - IF+LS every cycle, STARVE_MAX=3 -> grants LS,LS,LS,IF,LS,LS,LS,IF...;
//   stall_req_o=1 exactly on LS-grant cycles.
// - LS grant at 0x100 then IF at 0x10 -> ls_rvalid_o next cycle with word@0x100,
//   if_rvalid_o the cycle after with word@0x10; never both valid in one cycle.
// - IF grant at 0x20 with flush_i=1 next cycle -> if_rvalid_o stays 0,
//   if_rdata_o=0; LS response in the same flush cycle still delivered.
// - if_req_i dropped after 2 denials -> starve_cnt clears; re-request with LS
//   present needs 3 fresh denials before forced IF grant.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the single-port instruction ROM between the IF fetch port and the
// MEM-stage load port. Responses return one cycle after the grant.
module rom_fetch_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    input  logic              flush_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              stall_req_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_e     owner_q, owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       if_wins;

    always_comb begin
        // LS has priority unless IF has been denied STARVE_MAX times in a row
        if_wins     = if_req_i & (~ls_req_i | (starve_cnt_q == STARVE_LIM));
        if_gnt_o    = if_wins & ~rst;
        ls_gnt_o    = ls_req_i & ~if_wins & ~rst;
        rom_ce_o    = if_gnt_o | ls_gnt_o;
        stall_req_o = if_req_i & ~if_gnt_o & ~rst;

        rom_addr_o = '0;
        if (if_gnt_o) begin
            rom_addr_o = if_addr_i;
        end else if (ls_gnt_o) begin
            rom_addr_o = ls_addr_i;
        end

        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_gnt_o) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        owner_d = OWN_NONE;
        if (if_gnt_o) begin
            owner_d = flush_i ? OWN_NONE : OWN_IF;
        end else if (ls_gnt_o) begin
            owner_d = OWN_LS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        if_rvalid_o = (owner_q == OWN_IF) & ~flush_i;
        ls_rvalid_o = (owner_q == OWN_LS);
        if_rdata_o  = if_rvalid_o ? rom_data_i : '0;
        ls_rdata_o  = ls_rvalid_o ? rom_data_i : '0;
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a behavioural synchronous ROM.
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, ls_req_i, flush_i;
    logic [31:0] if_addr_i, ls_addr_i;
    logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, rom_ce_o, stall_req_o;
    logic [31:0] if_rdata_o, ls_rdata_o, rom_addr_o;
    logic [31:0] rom_data;

    int checks   = 0;
    int failures = 0;

    rom_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .flush_i(flush_i), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data), .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1234};
    endfunction

    always @(posedge clk) begin
        if (rom_ce_o) rom_data <= word(rom_addr_o);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_in(input logic ir, input logic [31:0] ia,
                          input logic lr, input logic [31:0] la, input logic fl);
        if_req_i = ir; if_addr_i = ia; ls_req_i = lr; ls_addr_i = la; flush_i = fl;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) next_cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 32'h40, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({if_gnt_o, ls_gnt_o, rom_ce_o, stall_req_o, if_rvalid_o, ls_rvalid_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: gnt/ce/stall/rvalid=%b required 000000",
                     {if_gnt_o, ls_gnt_o, rom_ce_o, stall_req_o, if_rvalid_o, ls_rvalid_o});
        end
        checks++;
        if (if_rdata_o !== 32'h0 || ls_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: if=%h ls=%h required 0", if_rdata_o, ls_rdata_o);
        end
        next_cyc();
        rst = 1'b0;
        // fetch 0x40 right after release
        @(negedge clk);
        checks++;
        if (if_gnt_o !== 1'b1 || rom_addr_o !== 32'h40) begin
            failures++;
            $display("FAIL post_reset_gnt: gnt=%b addr=%h required 1 00000040", if_gnt_o, rom_addr_o);
        end
        next_cyc();
        set_in(1, 32'h44, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== word(32'h40)) begin
            failures++;
            $display("FAIL post_reset_resp: rvalid=%b data=%h required 1 %h", if_rvalid_o, if_rdata_o, word(32'h40));
        end
        next_cyc();
        // owner_q is now IF for 0x44; reset mid-access
        rst = 1'b1;
        #1;
        checks++;
        if ({if_rvalid_o, ls_rvalid_o, rom_ce_o, if_gnt_o, stall_req_o} !== 5'b0 || if_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: rv/ce/gnt/stall=%b rdata=%h required 00000 0",
                     {if_rvalid_o, ls_rvalid_o, rom_ce_o, if_gnt_o, stall_req_o}, if_rdata_o);
        end
        next_cyc();
        rst = 1'b0;
        set_in(1, 32'h48, 0, 0, 0);
        next_cyc();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== word(32'h48)) begin
            failures++;
            $display("FAIL mid_reset_refetch: rvalid=%b data=%h required 1 %h", if_rvalid_o, if_rdata_o, word(32'h48));
        end
        next_cyc();
    endtask

    task automatic test_if_alone();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_in(1, addrs[i], 0, 0, 0);
            else       set_in(0, 0, 0, 0, 0);
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (if_gnt_o !== 1'b1 || ls_gnt_o !== 1'b0 || rom_ce_o !== 1'b1 ||
                    rom_addr_o !== addrs[i] || stall_req_o !== 1'b0) begin
                    failures++;
                    $display("FAIL if_alone_gnt[%0d]: gnt=%b ls=%b ce=%b addr=%h stall=%b required 1 0 1 %h 0",
                             i, if_gnt_o, ls_gnt_o, rom_ce_o, rom_addr_o, stall_req_o, addrs[i]);
                end
            end else begin
                checks++;
                if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0) begin
                    failures++;
                    $display("FAIL if_alone_idle: ce=%b addr=%h required 0 0", rom_ce_o, rom_addr_o);
                end
            end
            if (i > 0) begin
                checks++;
                if (if_rvalid_o !== 1'b1 || if_rdata_o !== word(addrs[i-1]) || ls_rvalid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL if_alone_resp[%0d]: rvalid=%b data=%h ls_rv=%b required 1 %h 0",
                             i, if_rvalid_o, if_rdata_o, ls_rvalid_o, word(addrs[i-1]));
                end
            end
            next_cyc();
        end
        idle(1);
    endtask

    task automatic test_starvation();
        // expected owner each cycle with STARVE_MAX=3: LS,LS,LS,IF repeating
        logic [7:0] if_pat = 8'b1000_1000;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) set_in(1, 32'h200, 1, 32'h300, 0);
            else       set_in(0, 0, 0, 0, 0);
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (if_gnt_o !== if_pat[i] || ls_gnt_o !== ~if_pat[i] || stall_req_o !== ~if_pat[i]) begin
                    failures++;
                    $display("FAIL starve_gnt[%0d]: if=%b ls=%b stall=%b required %b %b %b",
                             i, if_gnt_o, ls_gnt_o, stall_req_o, if_pat[i], ~if_pat[i], ~if_pat[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (if_rvalid_o !== if_pat[i-1] || ls_rvalid_o !== ~if_pat[i-1] ||
                    (if_pat[i-1] && if_rdata_o !== word(32'h200)) ||
                    (!if_pat[i-1] && ls_rdata_o !== word(32'h300))) begin
                    failures++;
                    $display("FAIL starve_resp[%0d]: if_rv=%b ls_rv=%b if_d=%h ls_d=%h required if_rv=%b",
                             i, if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o, if_pat[i-1]);
                end
            end
            next_cyc();
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        set_in(0, 0, 1, 32'h100, 0);
        @(negedge clk);
        checks++;
        if (ls_gnt_o !== 1'b1 || rom_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL b2b_ls_gnt: gnt=%b addr=%h required 1 00000100", ls_gnt_o, rom_addr_o);
        end
        next_cyc();
        set_in(1, 32'h10, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== word(32'h100) || if_rvalid_o !== 1'b0 ||
            if_rdata_o !== 32'h0 || if_gnt_o !== 1'b1 || rom_addr_o !== 32'h10) begin
            failures++;
            $display("FAIL b2b_ls_resp: ls_rv=%b ls_d=%h if_rv=%b if_d=%h gnt=%b addr=%h required 1 %h 0 0 1 00000010",
                     ls_rvalid_o, ls_rdata_o, if_rvalid_o, if_rdata_o, if_gnt_o, rom_addr_o, word(32'h100));
        end
        next_cyc();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== word(32'h10) || ls_rvalid_o !== 1'b0 || ls_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL b2b_if_resp: if_rv=%b if_d=%h ls_rv=%b ls_d=%h required 1 %h 0 0",
                     if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o, word(32'h10));
        end
        next_cyc();
    endtask

    task automatic test_flush();
        set_in(1, 32'h20, 0, 0, 0);
        next_cyc();
        // flush in the IF response cycle, with an LS grant in flight
        set_in(0, 0, 1, 32'h30, 1);
        @(negedge clk);
        checks++;
        if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0 || ls_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_resp: if_rv=%b if_d=%h ls_gnt=%b required 0 0 1", if_rvalid_o, if_rdata_o, ls_gnt_o);
        end
        next_cyc();
        set_in(1, 32'h24, 0, 0, 1);
        @(negedge clk);
        checks++;
        if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== word(32'h30) || if_gnt_o !== 1'b1 || rom_addr_o !== 32'h24) begin
            failures++;
            $display("FAIL flush_ls_and_gnt: ls_rv=%b ls_d=%h if_gnt=%b addr=%h required 1 %h 1 00000024",
                     ls_rvalid_o, ls_rdata_o, if_gnt_o, rom_addr_o, word(32'h30));
        end
        next_cyc();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL flush_in_grant: if_rv=%b if_d=%h required 0 0", if_rvalid_o, if_rdata_o);
        end
        next_cyc();
    endtask

    task automatic test_starve_clear();
        // IF,IF-less,then 4 contended cycles: LS x2, LS(if_req=0), LS,LS,LS,IF
        logic       ir_pat [7] = '{1, 1, 0, 1, 1, 1, 1};
        logic [6:0] if_exp = 7'b100_0000;
        for (int i = 0; i < 7; i++) begin
            set_in(ir_pat[i], 32'h400, 1, 32'h500, 0);
            @(negedge clk);
            checks++;
            if (if_gnt_o !== if_exp[i] || ls_gnt_o !== ~if_exp[i]) begin
                failures++;
                $display("FAIL starve_clear[%0d]: if=%b ls=%b required %b %b",
                         i, if_gnt_o, ls_gnt_o, if_exp[i], ~if_exp[i]);
            end
            next_cyc();
        end
        idle(1);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0);
        test_reset();
        idle(1);
        test_if_alone();
        test_starvation();
        test_back_to_back();
        test_flush();
        test_starve_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
